// File: rtl/led_pkg.sv
// Shared constants and types for the BCD converter / 7-segment scan display.
package led_pkg;

  // Converter states: wait for a start, then ten double-dabble steps.
  typedef enum logic {StIdle, StShift} conv_state_e;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Active-low anode enables; bit 0 drives the units digit.
  localparam logic [3:0] AN_IDX0 = 4'b1110;
  localparam logic [3:0] AN_IDX1 = 4'b1101;
  localparam logic [3:0] AN_IDX2 = 4'b1011;
  localparam logic [3:0] AN_IDX3 = 4'b0111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Anode pattern for a digit index.
  function automatic logic [3:0] an_onehot(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = AN_IDX0;
      2'd1:    an = AN_IDX1;
      2'd2:    an = AN_IDX2;
      default: an = AN_IDX3;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment glyph decoder.
module bcd_to_seg7
  import led_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank overrides the glyph; codes 10..15 never occur and decode dark.
  always_comb begin
    seg = GLYPH_BLANK;
    if (!blank) begin
      case (nib)
        4'd0:    seg = GLYPH_0;
        4'd1:    seg = GLYPH_1;
        4'd2:    seg = GLYPH_2;
        4'd3:    seg = GLYPH_3;
        4'd4:    seg = GLYPH_4;
        4'd5:    seg = GLYPH_5;
        4'd6:    seg = GLYPH_6;
        4'd7:    seg = GLYPH_7;
        4'd8:    seg = GLYPH_8;
        4'd9:    seg = GLYPH_9;
        default: seg = GLYPH_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/led_bcd_scan.sv
// Binary 0..1023 to four BCD digits (iterative double-dabble) driving a
// time-multiplexed 4-digit common-anode 7-segment display.
module led_bcd_scan
  import led_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          LZB      = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [9:0]  di,
  input  logic        st,
  output logic        busy,
  output logic        rdy,
  output logic [15:0] bcd,
  output logic [3:0]  AN,
  output logic [6:0]  SEG
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  // Converter state. The shift register holds {bcd[15:0], bin[9:0]}.
  conv_state_e state_q, state_d;
  logic [25:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic        rdy_q, rdy_d;
  logic [25:0] adj;

  // Scan state.
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;

  logic [3:0] nib;
  logic       blank;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    adj = sr_q;
    for (int k = 0; k < 4; k++) begin
      if (sr_q[10+4*k +: 4] >= 4'd5) begin
        adj[10+4*k +: 4] = sr_q[10+4*k +: 4] + 4'd3;
      end
    end
  end

  // Converter next-state: latch on start, then ten correct-and-shift steps.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    rdy_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (st) begin
          sr_d    = {16'h0000, di};
          cnt_d   = 4'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d  = {adj[24:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          // BCD field of the final shifted value.
          bcd_d   = adj[24:9];
          rdy_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Converter registers; clr aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      rdy_q   <= rdy_d;
    end
  end

  // Prescaler wraps every SCAN_DIV clocks and steps the digit index.
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Scan registers, free-running regardless of the converter.
  always_ff @(posedge clk) begin
    if (clr) begin
      pre_q <= '0;
      idx_q <= 2'd0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
    end
  end

  // Digit mux and leading-zero blanking; the units digit is always lit.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd0:    nib = bcd_q[3:0];
      2'd1:    nib = bcd_q[7:4];
      2'd2:    nib = bcd_q[11:8];
      default: nib = bcd_q[15:12];
    endcase
    if (LZB) begin
      case (idx_q)
        2'd3:    blank = (bcd_q[15:12] == 4'd0);
        2'd2:    blank = (bcd_q[15:8] == 8'd0);
        2'd1:    blank = (bcd_q[15:4] == 12'd0);
        default: blank = 1'b0;
      endcase
    end
    AN = blank ? AN_OFF : an_onehot(idx_q);
  end

  bcd_to_seg7 u_dec (
    .nib   (nib),
    .blank (blank),
    .seg   (SEG)
  );

  assign busy = (state_q == StShift);
  assign rdy  = rdy_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_led_bcd_scan.sv
// Directed bench for led_bcd_scan: conversion table with scan checks, plus
// sequences for continuous restart, ignored start, mid-conversion clear and
// counter linkage.
module tb_led_bcd_scan;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [15:0] ON_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [9:0]  di  = '0;
  logic        st  = 1'b0;
  logic        busy, rdy, busy2, rdy2;
  logic [15:0] bcd, bcd2;
  logic [3:0]  an, an2;
  logic [6:0]  seg, seg2;

  int total = 0;
  int bad   = 0;

  // Expected digit position, tracked from clr (4 clocks per slot).
  int m_pre = 0;
  int m_idx = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      m_pre <= 0;
      m_idx <= 0;
    end else if (m_pre == 3) begin
      m_pre <= 0;
      m_idx <= (m_idx + 1) % 4;
    end else begin
      m_pre <= m_pre + 1;
    end
  end

  led_bcd_scan #(.SCAN_DIV(4), .LZB(1'b1)) dut (
    .clk (clk), .clr (clr), .di (di), .st (st), .busy (busy), .rdy (rdy),
    .bcd (bcd), .AN (an), .SEG (seg)
  );

  led_bcd_scan #(.SCAN_DIV(4), .LZB(1'b0)) dut_nb (
    .clk (clk), .clr (clr), .di (di), .st (st), .busy (busy2), .rdy (rdy2),
    .bcd (bcd2), .AN (an2), .SEG (seg2)
  );

  // Per-slot expectations packed {idx3, idx2, idx1, idx0}.
  typedef struct {
    logic [9:0]  di;
    logic [15:0] bcd;
    logic [15:0] an;
    logic [27:0] seg;
    logic [27:0] segnb;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance at least one edge, stop when rdy is seen; n = edges taken.
  task automatic wait_rdy(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (rdy !== 1'b1 && n < 40);
  endtask

  task automatic convert(input logic [9:0] v, input logic [15:0] exp);
    int n;
    @(negedge clk);
    di = v;
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_rdy(n);
    chk("rdy_latency", n, 10);
    chk("bcd", {16'd0, bcd}, {16'd0, exp});
    chk("bcd_nb", {16'd0, bcd2}, {16'd0, exp});
    chk("busy_at_rdy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("rdy_one_cycle", {31'd0, rdy}, 32'd0);
  endtask

  task automatic scan_check(input vec_t v);
    repeat (16) begin
      @(negedge clk);
      chk("an", {28'd0, an}, {28'd0, v.an[4*m_idx +: 4]});
      chk("seg", {25'd0, seg}, {25'd0, v.seg[7*m_idx +: 7]});
      chk("an_nb", {28'd0, an2}, {28'd0, ON_ALL[4*m_idx +: 4]});
      chk("seg_nb", {25'd0, seg2}, {25'd0, v.segnb[7*m_idx +: 7]});
    end
  endtask

  initial begin
    int n;
    int rcnt;
    int q;

    vecs[0] = '{10'd999, 16'h0999, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {BL, G9, G9, G9}, {G0, G9, G9, G9}};
    vecs[1] = '{10'd1023, 16'h1023, ON_ALL, {G1, G0, G2, G3}, {G1, G0, G2, G3}};
    vecs[2] = '{10'd0, 16'h0000, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {BL, BL, BL, G0}, {G0, G0, G0, G0}};
    vecs[3] = '{10'd100, 16'h0100, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {BL, G1, G0, G0}, {G0, G1, G0, G0}};
    vecs[4] = '{10'd57, 16'h0057, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {BL, BL, G5, G7}, {G0, G0, G5, G7}};
    vecs[5] = '{10'd468, 16'h0468, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {BL, G4, G6, G8}, {G0, G4, G6, G8}};
    vecs[6] = '{10'd10, 16'h0010, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {BL, BL, G1, G0}, {G0, G0, G1, G0}};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    chk("rst_bcd", {16'd0, bcd}, 32'd0);
    chk("rst_an", {28'd0, an}, 32'hE);
    chk("rst_seg", {25'd0, seg}, {25'd0, G0});
    @(negedge clk);
    clr = 1'b0;

    // Table: convert, then watch a full scan cycle on both instances.
    for (int i = 0; i < 7; i++) begin
      convert(vecs[i].di, vecs[i].bcd);
      scan_check(vecs[i]);
    end

    // Continuous restart: st held, di 1 -> 2 -> 3; di changes mid-shift ignored.
    @(negedge clk);
    di = 10'd1;
    st = 1'b1;
    @(posedge clk);
    #1;
    wait_rdy(n);
    chk("cont_lat1", n, 10);
    chk("cont_bcd1", {16'd0, bcd}, 32'h0001);
    di = 10'd2;
    wait_rdy(n);
    chk("cont_period2", n, 11);
    chk("cont_bcd2", {16'd0, bcd}, 32'h0002);
    di = 10'd3;
    @(posedge clk);
    #1;
    chk("cont_busy3", {31'd0, busy}, 32'd1);
    di = 10'd7;
    wait_rdy(n);
    chk("cont_period3", n + 1, 11);
    chk("cont_bcd3", {16'd0, bcd}, 32'h0003);
    st = 1'b0;
    @(posedge clk);
    #1;
    chk("cont_stop", {31'd0, busy}, 32'd0);

    // Start pulse while busy is ignored and gives no extra rdy.
    @(negedge clk);
    di = 10'd5;
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    di = 10'd8;
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    wait_rdy(n);
    chk("ign_lat", n, 6);
    chk("ign_bcd", {16'd0, bcd}, 32'h0005);
    rcnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rdy) rcnt++;
    end
    chk("ign_no_extra_rdy", rcnt, 0);

    // clr at the 5th SHIFT edge aborts the conversion.
    @(negedge clk);
    di = 10'd999;
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_bcd", {16'd0, bcd}, 32'd0);
    chk("clr_rdy", {31'd0, rdy}, 32'd0);
    chk("clr_an", {28'd0, an}, 32'hE);
    chk("clr_seg", {25'd0, seg}, {25'd0, G0});
    rcnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rdy) rcnt++;
    end
    chk("clr_no_rdy", rcnt, 0);

    // st and clr together: clr wins.
    convert(10'd42, 16'h0042);
    @(negedge clk);
    clr = 1'b1;
    st  = 1'b1;
    di  = 10'd50;
    @(posedge clk);
    #1;
    clr = 1'b0;
    st  = 1'b0;
    chk("stclr_busy", {31'd0, busy}, 32'd0);
    chk("stclr_bcd", {16'd0, bcd}, 32'd0);
    @(posedge clk);
    #1;
    chk("stclr_busy2", {31'd0, busy}, 32'd0);

    // Counter linkage: decimal counter from 998, st = CEO (TC at 999).
    q = 998;
    repeat (4) begin
      @(negedge clk);
      di = 10'(q);
      st = (q == 999);
      @(posedge clk);
      q = (q == 999) ? 0 : q + 1;
    end
    @(negedge clk);
    st = 1'b0;
    #1;
    wait_rdy(n);
    chk("ctr_rdy_seen", {31'd0, rdy}, 32'd1);
    chk("ctr_bcd", {16'd0, bcd}, 32'h0999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_bcd_scan.md
# led_bcd_scan

Downstream display stage for the 10-bit up/down decimal counter. It takes the counter's binary value 0..1023 and converts it to four BCD digits with an iterative double-dabble FSM. It then drives a 4-digit common-anode 7-segment display by time-multiplexing the digits. It sits between the counter's `Q`/`CEO` outputs and the board's `AN`/`SEG` pins.

## Interface
- `SCAN_DIV`, default 50000: clocks per digit slot; must be ≥ 2. At 50 MHz this gives a 1 kHz digit rate.
- `LZB`, default 1: leading-zero blanking. 1 = enabled, 0 = all four digits always shown.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `clr` in 1: reset, synchronous and active-high.
- `di` in 10: binary value to display, from the counter's `Q`.
- `st` in 1: conversion start. Sampled only in IDLE. Typically tied to counter `CEO`, a load strobe, or 1.
- `busy` out 1: conversion in progress.
- `rdy` out 1: one-cycle pulse when `bcd` has just been updated.
- `bcd` out 16: digits {thousands, hundreds, tens, units}, 4 bits each.
- `AN` out 4: digit enables, active-low. Bit 0 = units.
- `SEG` out 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- **Converter FSM states**: IDLE, SHIFT.
- **IDLE**:
  - If `st`=1: latch `di` into a 26-bit shift register (16 BCD bits zeroed plus the 10 binary bits), set bit counter = 0, go to SHIFT.
  - If `st`=0: stay in IDLE.
- **SHIFT**, once per clock:
  - Add 3 to each BCD nibble that is ≥ 5.
  - Then shift the whole register left by 1 and increment the bit counter.
  - After the 10th shift, copy the BCD field to `bcd`, pulse `rdy`, and return to IDLE.
- **Start handling**:
  - `st` is ignored while in SHIFT. There is no queueing.
  - `di` changes during SHIFT have no effect on the result.
- **Range**: full 0..1023 is converted exactly. 1000..1023 shows a nonzero thousands digit. No saturation.
- **Scan path**:
  - A prescaler counts 0..SCAN_DIV-1 and wraps.
  - At the wrap, the 2-bit digit index advances 0→1→2→3→0.
  - The scan runs continuously and independently of the converter.
- **Outputs**:
  - `AN` is one-hot low at the index position: idx0 = 1110, idx1 = 1101, idx2 = 1011, idx3 = 0111.
  - `SEG` is the glyph of the indexed nibble.
  - Both are combinational from registered idx and `bcd`.
- **Glyphs** (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles 10..15 are unreachable; decode them as blank (1111111).
- **Blanking** (LZB=1):
  - Thousands digit blanked if it is 0.
  - Hundreds digit blanked if thousands and hundreds are both 0.
  - Tens digit blanked if the upper three digits are all 0.
  - Units digit is never blanked.
  - A blanked slot drives `AN`=1111 and `SEG`=1111111.
- **`bcd` update mid-slot**: the currently lit digit reflects the new value from the next cycle. This is accepted.

## Timing
- **Reset values** (`clr`=1 at an edge; overrides everything, including a conversion in SHIFT, which is aborted):
  - FSM = IDLE, `busy`=0, `rdy`=0, `bcd`=16'h0000.
  - Prescaler = 0, idx = 0.
  - Resulting outputs: `AN`=1110, `SEG`=1000000.
- **Conversion latency**, with `st`=1 sampled in IDLE at edge N:
  - `busy`=1 after edge N.
  - SHIFT edges are N+1..N+10.
  - After edge N+10: `bcd` is valid, `rdy`=1, `busy`=0.
  - After edge N+11: `rdy`=0.
- **Continuous restart**: with `st` held at 1, the next acceptance is at edge N+11, so the conversion period is 11 clocks.
- **Scan timing**: idx changes at the edge where the prescaler wraps from SCAN_DIV-1. Each digit is lit for exactly SCAN_DIV clocks.
- **`st` and `clr` in the same cycle**: `clr` wins and no conversion starts.

## Structure
- **Package `led_pkg`**:
  - The 10 glyph constants and the blank constant.
  - The converter state typedef (IDLE/SHIFT).
  - The `AN` one-hot patterns.
- **Sub-module `bcd_to_seg7`**: combinational 4-bit nibble to 7-bit active-low glyph decoder with a blank input.
- **Top level**: instantiates the decoder once, after the digit mux.

## Test plan
- `di`=999, `st` pulse: `rdy` 10 cycles after acceptance, `bcd`=16'h0999. With LZB=1 and SCAN_DIV=4, the scan shows idx3 blank (`AN`=1111), then 9,9,9 (`SEG`=0010000), each slot 4 clocks.
- `di`=1023: `bcd`=16'h1023, all four digits lit. `di`=0: `bcd`=16'h0000, only units lit with `SEG`=1000000. With LZB=0, all four digits show 0.
- `st` held at 1, `di` stepping 1→2→3: `rdy` every 11 cycles, and `bcd` follows with 10-cycle latency. A `st` pulse during `busy` is ignored and gives no extra `rdy`.
- `clr` asserted at the 5th SHIFT cycle: next cycle shows `busy`=0, `bcd`=0, `rdy` never pulses, `AN`=1110, `SEG`=1000000.
- `di`=100 with LZB=1: digits blank,1,0,0. The inner zeros must be shown, not blanked.
- Counter bench linkage: counter counting up from 998 with `st`=CEO. A conversion triggers at 999 (TC) and yields 16'h0999.
